pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 12: program-counter width in bits.
REQ-002 SHALL have parameter LABEL_W, default 26: branch label width; must be at least PC_W.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port stall, input, 1 bit: hold PC and stack this cycle.
REQ-008 SHALL have port isBranch, input, 1 bit: a control transfer is requested this cycle.
REQ-009 SHALL have port br_mode, input, 2 bits: 00 absolute jump, 01 PC-relative, 10 call, 11 return.
REQ-010 SHALL have port label, input, LABEL_W bits: branch target or offset.
REQ-011 SHALL have port pc, output, PC_W bits: current program counter, registered.
REQ-012 SHALL have port ras_empty, output, 1 bit: stack holds no entries.
REQ-013 SHALL have port ras_full, output, 1 bit: stack holds RAS_DEPTH entries.
REQ-014 SHALL have port ras_depth, output, clog2(RAS_DEPTH)+1 bits: current entry count.
REQ-015 SHALL have port ras_ovf, output, 1 bit: one-cycle pulse when a call hits a full stack.
REQ-016 SHALL have port ras_unf, output, 1 bit: one-cycle pulse when a return hits an empty stack.

Function
REQ-017 With stall=0 and isBranch=0, pc SHALL update to (pc+1) mod 2^PC_W, so all-ones wraps to 0.
REQ-018 On an absolute jump (isBranch=1, mode 00), pc SHALL load label[PC_W-1:0]; upper label bits are ignored.
REQ-019 On a PC-relative branch (mode 01), pc SHALL load pc + signed(label[PC_W-1:0]) mod 2^PC_W.
REQ-020 On a call (mode 10) with the stack not full, the block SHALL push pc+1, load pc from label[PC_W-1:0], and increment ras_depth, all on the same edge.
REQ-021 On a call with the stack full, pc SHALL still load the target, the stack and ras_depth SHALL stay unchanged, and ras_ovf SHALL pulse for one cycle.
REQ-022 On a return (mode 11) with the stack not empty, pc SHALL load the top entry and ras_depth SHALL decrement.
REQ-023 On a return with the stack empty, pc SHALL update to pc+1 and ras_unf SHALL pulse for one cycle.
REQ-024 stall=1 SHALL take priority over everything: pc, stack and ras_depth hold; isBranch is ignored; ras_ovf and ras_unf stay 0.
REQ-025 Latency SHALL be one cycle: the new pc is visible after the rising edge that samples the request.
REQ-026 The stack SHALL be LIFO with a pointer and no wrap; ras_full is (ras_depth==RAS_DEPTH) and ras_empty is (ras_depth==0), both combinational from registered depth.
REQ-027 ras_ovf and ras_unf SHALL be registered and deassert on the next unstalled or stalled edge.

Reset
REQ-028 While rst=0, pc SHALL be RESET_PC, ras_depth 0, ras_empty 1, ras_full 0, ras_ovf 0, ras_unf 0, asynchronously.
REQ-029 Reset asserted mid-sequence, including mid call chain, SHALL discard all stack contents.
REQ-030 Stack storage SHALL need no reset; only the pointer/depth is reset.

Structure
REQ-031 A shared package SHALL hold the br_mode encodings (BR_ABS, BR_REL, BR_CALL, BR_RET) and default widths.
REQ-032 The stack SHALL be one sub-module, pc_ras (push, pop, top, depth, full, empty); next-PC selection stays in pc_sequencer.

Verification
REQ-033 Reset with RESET_PC=0, release, 3 unstalled edges -> pc 0, 1, 2, 3.
REQ-034 At pc=5, absolute jump with label=24 -> pc=24; then relative jump with label[11:0]=12'hFFD -> pc=21.
REQ-035 At pc=4095 with no branch -> pc=0; with stall=1 held 3 cycles and isBranch=1 -> pc stays constant.
REQ-036 Call at pc=10 to 100, call at pc=100 to 200, return, return -> pc 100, 200, 101, 11; ras_depth 1, 2, 1, 0.
REQ-037 Make 5 calls with RAS_DEPTH=4 -> ras_full after the 4th, ras_ovf pulses once on the 5th, ras_depth stays 4; then 4 returns pop in LIFO order.
REQ-038 Return with an empty stack at pc=7 -> pc=8 and ras_unf high for exactly one cycle; assert rst after two calls -> depth 0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: branch mode encodings
// and default widths used by pc_sequencer and its return-address stack.
package pc_sequencer_pkg;

  localparam int PC_W_DEF      = 12;
  localparam int LABEL_W_DEF   = 26;
  localparam int RAS_DEPTH_DEF = 4;
  localparam int RESET_PC_DEF  = 0;

  typedef enum logic [1:0] {
    BR_ABS  = 2'b00,
    BR_REL  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_mode_e;

  // Entry count needs one extra bit so a full stack is distinguishable from empty.
  function automatic int ras_depth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: pointer-based LIFO without wrap. Only the entry count
// is reset; storage is left uninitialised and is only read below the count.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_W = PC_W_DEF,
  parameter int DEPTH  = RAS_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = ras_depth_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_top,
  output logic [DW-1:0]     o_depth,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DW-1:0]     r_depth;
  logic [AW-1:0]     w_top_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_depth == DW'(DEPTH));
  assign o_empty   = (r_depth == '0);
  assign o_depth   = r_depth;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Low bits of a full count are zero, so subtracting one still lands on DEPTH-1.
  assign w_top_idx = r_depth[AW-1:0] - AW'(1);
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_depth[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, absolute/relative jumps, call/return
// through pc_ras, with stall priority and registered overflow/underflow pulses.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEF,
  parameter int          LABEL_W   = LABEL_W_DEF,
  parameter int          RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned RESET_PC  = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       isBranch,
  input  logic [1:0]                 br_mode,
  input  logic [LABEL_W-1:0]         label,
  output logic [PC_W-1:0]            pc,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic [$clog2(RAS_DEPTH):0] ras_depth,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  logic [PC_W-1:0] r_pc;
  logic            r_ovf;
  logic            r_unf;

  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_top;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_ovf_next;
  logic            w_unf_next;

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_target = label[PC_W-1:0];

  // Upper label bits carry no meaning for a PC_W-wide target.
  generate
    if (LABEL_W > PC_W) begin : g_label_hi
      logic w_unused_label_hi;
      assign w_unused_label_hi = ^label[LABEL_W-1:PC_W];
    end
  endgenerate

  pc_ras #(
    .DATA_W (PC_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_depth (ras_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_pc_next  = w_pc_inc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_ovf_next = 1'b0;
    w_unf_next = 1'b0;
    if (stall) begin
      w_pc_next = r_pc;
    end else if (isBranch) begin
      case (br_mode_e'(br_mode))
        BR_ABS: w_pc_next = w_target;
        // Two's-complement add of the low label bits is the signed offset mod 2^PC_W.
        BR_REL: w_pc_next = r_pc + w_target;
        BR_CALL: begin
          w_pc_next  = w_target;
          w_push     = !w_full;
          w_ovf_next = w_full;
        end
        BR_RET: begin
          if (w_empty) begin
            w_unf_next = 1'b1;
          end else begin
            w_pop     = 1'b1;
            w_pc_next = w_top;
          end
        end
        default: w_pc_next = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= PC_W'(RESET_PC);
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_ovf <= w_ovf_next;
      r_unf <= w_unf_next;
    end
  end

  assign pc        = r_pc;
  assign ras_full  = w_full;
  assign ras_empty = w_empty;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule
